// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller.
// Pure declarations; no timing or flow control of its own.
package btb_pkg;

  localparam logic [1:0] CNTR_WEAK_T   = 2'b10;
  localparam logic [1:0] CNTR_STRONG_T = 2'b11;
  localparam logic [1:0] BTYPE_COND    = 2'b00;
  localparam logic [1:0] BTYPE_JUMP    = 2'b10;

  typedef struct packed {
    logic [29:0] vpc;
    logic [31:0] target;
    logic [1:0]  cntr;
    logic        tkn;
    logic [1:0]  btype;
    logic        hit;
    logic        way;
  } upd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_WRITE
  } upd_state_t;

  // Saturating bimodal counter step toward the resolved direction.
  function automatic logic [1:0] cntr_step(input logic [1:0] cntr, input logic tkn);
    logic [1:0] res;
    res = cntr;
    if (tkn && cntr != 2'b11) res = cntr + 2'b01;
    if (!tkn && cntr != 2'b00) res = cntr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending-update FIFO: DEPTH entries, registered pointers with a wrap bit.
// Head visible combinationally; flush discards all entries; caller gates push on full.
module btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/btb_update_ctrl.sv
// Queues branch resolutions and turns them into BTB writes (BTB_UPD_PERF_EN adds perf counters).
// Latency: resolution into idle/empty queue -> write request two cycles later.
// Backpressure: write held until granted; resolutions arriving with a full queue are dropped.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        flush_i,
  input  logic        bu_valid_i,
  input  logic [29:0] bu_vpc_i,
  input  logic [31:0] bu_target_i,
  input  logic [1:0]  bu_cntr_i,
  input  logic        bu_tkn_i,
  input  logic [1:0]  bu_type_i,
  input  logic        bu_hit_i,
  input  logic        bu_way_i,
  output logic        btb_wr_en_o,
  input  logic        btb_wr_gnt_i,
  output logic [29:0] btb_wr_vpc_o,
  output logic        btb_wr_way_o,
  output logic [29:0] btb_wr_target_o,
  output logic [1:0]  btb_wr_cntr_o,
  output logic [1:0]  btb_wr_type_o,
  output logic        btb_wr_vld_o
`ifdef BTB_UPD_PERF_EN
  ,
  output logic [7:0]  perf_drop_o,
  output logic [15:0] perf_wr_o
`endif
);

  upd_state_t state_q, state_d;
  upd_entry_t in_ent, head_ent, hold_q;

  logic enq_req, push, pop, bypass, start_wr, grant;
  logic fifo_full, fifo_empty;

  logic       repl_q, alloc_q;
  logic [1:0] last_vld;
  logic [1:0][29:0] last_vpc;
  logic [1:0][31:0] last_tgt;

  logic       same_tgt, is_cond, need_wr, alloc;
  logic [1:0] new_cntr;
  logic       new_way;

  assign in_ent = '{vpc: bu_vpc_i, target: bu_target_i, cntr: bu_cntr_i, tkn: bu_tkn_i,
                    btype: bu_type_i, hit: bu_hit_i, way: bu_way_i};

  assign enq_req = bu_valid_i & ~flush_i;
  assign push    = enq_req & ~bypass & (~fifo_full | pop);
  assign grant   = btb_wr_en_o & btb_wr_gnt_i;

  btb_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(upd_entry_t))
  ) u_fifo (
    .clk      (cpu_clock_i),
    .rst      (cpu_reset_i),
    .flush    (flush_i),
    .push     (push),
    .push_dat (in_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // An idle controller with nothing queued takes the resolution straight into the holding register.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    bypass   = 1'b0;
    start_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_EVAL;
          end else if (bu_valid_i) begin
            bypass  = 1'b1;
            state_d = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        if (need_wr) begin
          start_wr = 1'b1;
          state_d  = ST_WRITE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (btb_wr_gnt_i) state_d = ST_WRITE == state_q ? ST_IDLE : state_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i)  hold_q <= '0;
    else if (pop)     hold_q <= head_ent;
    else if (bypass)  hold_q <= in_ent;
  end

  // The resolution carries no stored BTB target, so compare against the last entry written
  // to that way; anything unknown is treated as changed.
  assign same_tgt = last_vld[hold_q.way] &&
                    (last_vpc[hold_q.way] == hold_q.vpc) &&
                    (last_tgt[hold_q.way] == hold_q.target);
  assign is_cond  = (hold_q.btype != BTYPE_JUMP);

  always_comb begin
    new_cntr = CNTR_STRONG_T;
    new_way  = hold_q.way;
    need_wr  = 1'b0;
    alloc    = 1'b0;
    if (hold_q.hit) begin
      if (is_cond) begin
        new_cntr = cntr_step(hold_q.cntr, hold_q.tkn);
        need_wr  = (new_cntr != hold_q.cntr) || !same_tgt;
      end else begin
        need_wr  = !same_tgt;
      end
    end else begin
      new_cntr = is_cond ? CNTR_WEAK_T : CNTR_STRONG_T;
      new_way  = repl_q;
      need_wr  = hold_q.tkn;
      alloc    = hold_q.tkn;
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      btb_wr_en_o     <= 1'b0;
      btb_wr_vpc_o    <= '0;
      btb_wr_way_o    <= 1'b0;
      btb_wr_target_o <= '0;
      btb_wr_cntr_o   <= '0;
      btb_wr_type_o   <= '0;
      btb_wr_vld_o    <= 1'b0;
      alloc_q         <= 1'b0;
    end else if (start_wr) begin
      btb_wr_en_o     <= 1'b1;
      btb_wr_vpc_o    <= hold_q.vpc;
      btb_wr_way_o    <= new_way;
      btb_wr_target_o <= hold_q.target[31:2];
      btb_wr_cntr_o   <= new_cntr;
      btb_wr_type_o   <= hold_q.btype;
      btb_wr_vld_o    <= 1'b1;
      alloc_q         <= alloc;
    end else if (grant) begin
      btb_wr_en_o     <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      repl_q   <= 1'b0;
      last_vld <= '0;
      last_vpc <= '0;
      last_tgt <= '0;
    end else if (grant) begin
      if (alloc_q) repl_q <= ~repl_q;
      last_vld[btb_wr_way_o] <= 1'b1;
      last_vpc[btb_wr_way_o] <= hold_q.vpc;
      last_tgt[btb_wr_way_o] <= hold_q.target;
    end
  end

`ifdef BTB_UPD_PERF_EN
  logic drop;
  assign drop = enq_req & fifo_full & ~pop;

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      perf_drop_o <= '0;
      perf_wr_o   <= '0;
    end else begin
      if (drop && perf_drop_o != 8'hFF) perf_drop_o <= perf_drop_o + 8'd1;
      if (grant)                        perf_wr_o   <= perf_wr_o + 16'd1;
    end
  end
`endif

endmodule
